// File: rtl/formic_bctl_trace_out_pkg.sv
// Shared constants and types for the trace-link transmit block.
package formic_bctl_trace_out_pkg;

    // Bytes per trace record; the receiver counts this many valid bytes.
    localparam int PKT_BYTES  = 8;
    localparam int CNT_W      = 3;
    localparam int FIFO_DEPTH = 64;
    localparam int ADDR_W     = 6;
    localparam int WORDS_W    = 7;

    localparam logic [WORDS_W-1:0] REC_WORDS = WORDS_W'(PKT_BYTES);

    // One-hot transmit states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_GAP  = 3'b100
    } tx_state_e;

    // True when a word count covers at least 'need' words.
    function automatic logic has_words(input logic [WORDS_W-1:0] words,
                                       input logic [WORDS_W-1:0] need);
        return words >= need;
    endfunction

endpackage

// File: rtl/fifo_align_64x8.sv
// 64x8 first-word-fall-through FIFO with free and used word counts.
// The head word is always visible on rd_data; rd_en pops it.
module fifo_align_64x8
    import formic_bctl_trace_out_pkg::*;
(
    input  logic               wr_clk,
    input  logic               rd_clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic [WORDS_W-1:0] o_wr_words,
    output logic [WORDS_W-1:0] o_rd_words
);

    logic [7:0]         mem [0:FIFO_DEPTH-1];
    logic [WORDS_W-1:0] wr_ptr;
    logic [WORDS_W-1:0] rd_ptr;
    logic [WORDS_W-1:0] used;
    logic               wr_ok;
    logic               rd_ok;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign used       = wr_ptr - rd_ptr;
    assign o_rd_words = used;
    assign o_wr_words = WORDS_W'(FIFO_DEPTH) - used;
    assign wr_ok      = wr_en && (o_wr_words != '0);
    assign rd_ok      = rd_en && (used != '0);
    assign rd_data    = mem[rd_ptr[ADDR_W-1:0]];

    // Storage write, kept free of reset so it maps onto plain RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Write pointer advance.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advance (pop of the head word).
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/formic_bctl_trace_out.sv
// Transmit end of the byte-serial trace link: admits whole 8-byte records
// into a FIFO, drops whole records on overrun, and sends each buffered
// record as an uninterrupted 8-byte burst.
//
// Link handshake: o_valid qualifies o_data for exactly one cycle per byte and
// there is no per-byte ready. i_hold is the only back-pressure and is honoured
// only at burst boundaries, so a started burst always runs to 8 bytes.
module formic_bctl_trace_out
    import formic_bctl_trace_out_pkg::*;
#(
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_enq,
    input  logic       i_hold,
    input  logic       i_clr_drop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_drop,
    output logic [7:0] o_drop_cnt,
    output logic       o_busy
);

    localparam logic [3:0]       GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);

    logic [WORDS_W-1:0] free_words;
    logic [WORDS_W-1:0] used_words;
    logic [7:0]         rd_data;
    logic               wr_en;
    logic               rd_en;
    logic               room;
    logic               rec_start;
    logic               drop_now;
    logic               launch;
    logic               launch_next;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               admit;
    logic [3:0]         gap_cnt;
    tx_state_e          state;

    fifo_align_64x8 u_fifo (
        .wr_clk     (clk),
        .rd_clk     (clk),
        .rst        (~rst_n),
        .wr_en      (wr_en),
        .wr_data    (i_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .o_wr_words (free_words),
        .o_rd_words (used_words)
    );

    // The admit decision is taken at a record's first byte only.
    assign room      = has_words(free_words, REC_WORDS);
    assign rec_start = i_enq && (w_cnt == '0);
    assign drop_now  = rec_start && !room;
    assign wr_en     = i_enq && (rec_start ? room : admit);
    assign rd_en     = (state == ST_SEND);

    // A burst may start only when a whole record is buffered. On the last
    // Send cycle the used count still includes the byte being popped, so a
    // follow-on record needs one more word.
    assign launch      = has_words(used_words, REC_WORDS) && !i_hold;
    assign launch_next = has_words(used_words, REC_WORDS + 7'd1) && !i_hold;

    assign o_busy = (used_words != '0) || (state != ST_IDLE) || o_valid;

    // Record byte counter, latched admit decision and drop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_cnt  <= '0;
            admit  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            o_drop <= drop_now;
            if (i_enq) begin
                w_cnt <= w_cnt + 1'b1;
                if (rec_start) begin
                    admit <= room;
                end
            end
        end
    end

    // Saturating count of discarded records; a coincident clear keeps the new drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_drop_cnt <= '0;
        end else if (i_clr_drop) begin
            o_drop_cnt <= drop_now ? 8'd1 : 8'd0;
        end else if (drop_now && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    // Transmit FSM: Idle waits for a whole record, Send pops 8 bytes, Gap idles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            r_cnt   <= '0;
            gap_cnt <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_valid <= 1'b0;
                    r_cnt   <= '0;
                    if (launch) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    o_data  <= rd_data;
                    o_valid <= 1'b1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) begin
                        if (GAP == 0) begin
                            state <= launch_next ? ST_SEND : ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
                end
                ST_GAP: begin
                    // The last Gap cycle doubles as the Idle decision point
                    // so the link sees exactly GAP idle cycles.
                    o_valid <= 1'b0;
                    if (gap_cnt == '0) begin
                        state <= launch ? ST_SEND : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
